// File: rtl/speicher_antwort.sv
// speicher_antwort -- memory-side responder for the controller's level
// handshakes (fetch, data load, data store) in front of a single-port
// synchronous RAM with a fixed read latency.
//
// Parameters
//   LATENZ  RAM read latency, address/enable edge to valid MemLeseDaten (1..15)
//   AW      RAM word-address width
// Ports
//   Clock, Reset (async, active-high)
//   LoadBefehlSignal / BefehlAdresse           fetch request, byte address
//   LoadDatenSignal / StoreDatenSignal         data load / store request
//   DatenAdresse / SchreibDaten                load/store byte address, store data
//   Befehl / LeseDaten                         registered read results
//   BefehlGeladen / DatenGeladen / DatenGespeichert   four-phase acks
//   Ausrichtungsfehler                         misaligned access flag
//   MemEnable / MemSchreiben / MemAdresse / MemSchreibDaten / MemLeseDaten
//
// Build option: define SPEICHER_AUSRICHTUNG_EN to answer accesses with
// address bits [1:0] != 0 immediately with an ack plus Ausrichtungsfehler and
// no RAM cycle. Without it those bits are ignored and the flag stays 0.
module speicher_antwort #(
  parameter int LATENZ = 2,
  parameter int AW     = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          LoadBefehlSignal,
  input  logic [31:0]   BefehlAdresse,
  input  logic          LoadDatenSignal,
  input  logic          StoreDatenSignal,
  input  logic [31:0]   DatenAdresse,
  input  logic [31:0]   SchreibDaten,
  output logic [31:0]   Befehl,
  output logic [31:0]   LeseDaten,
  output logic          BefehlGeladen,
  output logic          DatenGeladen,
  output logic          DatenGespeichert,
  output logic          Ausrichtungsfehler,
  output logic          MemEnable,
  output logic          MemSchreiben,
  output logic [AW-1:0] MemAdresse,
  output logic [31:0]   MemSchreibDaten,
  input  logic [31:0]   MemLeseDaten
);

  typedef enum logic [2:0] {IDLE, LESEN, SCHREIBEN, QUITT, ABBRUCH} state_t;

  localparam logic [3:0] LAT4 = 4'(LATENZ);

  state_t        state, state_nx;
  logic [3:0]    zaehler, zaehler_nx;
  logic          quelle_befehl, quelle_befehl_nx;   // 1: fetch, 0: data load
  logic [31:0]   befehl_nx, lese_daten_nx, schreib_daten_nx;
  logic          bg_nx, dg_nx, ds_nx, fehler_nx, en_nx, wr_nx;
  logic [AW-1:0] adresse_nx;

  logic          fehl_daten, fehl_befehl;
  logic          lese_anfrage;   // request level of the read in flight
  logic          quitt_halten;   // originating request of the pending ack still high
  logic          unused_bits;

`ifdef SPEICHER_AUSRICHTUNG_EN
  assign fehl_daten  = |DatenAdresse[1:0];
  assign fehl_befehl = |BefehlAdresse[1:0];
`else
  assign fehl_daten  = 1'b0;
  assign fehl_befehl = 1'b0;
`endif

  // Upper address bits (and [1:0] when unchecked) are deliberately ignored.
  assign unused_bits = ^{BefehlAdresse, DatenAdresse};

  assign lese_anfrage = quelle_befehl ? LoadBefehlSignal : LoadDatenSignal;
  // Only one ack is ever set, so it identifies the request to watch.
  assign quitt_halten = (BefehlGeladen    & LoadBefehlSignal) |
                        (DatenGeladen     & LoadDatenSignal)  |
                        (DatenGespeichert & StoreDatenSignal);

  always_comb begin
    state_nx         = state;
    zaehler_nx       = zaehler;
    quelle_befehl_nx = quelle_befehl;
    befehl_nx        = Befehl;
    lese_daten_nx    = LeseDaten;
    schreib_daten_nx = MemSchreibDaten;
    adresse_nx       = MemAdresse;
    bg_nx            = BefehlGeladen;
    dg_nx            = DatenGeladen;
    ds_nx            = DatenGespeichert;
    fehler_nx        = Ausrichtungsfehler;
    en_nx            = MemEnable;
    wr_nx            = MemSchreiben;

    case (state)
      IDLE: begin
        if (StoreDatenSignal) begin
          if (fehl_daten) begin
            state_nx  = QUITT;
            ds_nx     = 1'b1;
            fehler_nx = 1'b1;
          end else begin
            state_nx         = SCHREIBEN;
            en_nx            = 1'b1;
            wr_nx            = 1'b1;
            adresse_nx       = DatenAdresse[AW+1:2];
            schreib_daten_nx = SchreibDaten;
          end
        end else if (LoadDatenSignal) begin
          if (fehl_daten) begin
            state_nx  = QUITT;
            dg_nx     = 1'b1;
            fehler_nx = 1'b1;
          end else begin
            state_nx         = LESEN;
            en_nx            = 1'b1;
            wr_nx            = 1'b0;
            adresse_nx       = DatenAdresse[AW+1:2];
            zaehler_nx       = LAT4;
            quelle_befehl_nx = 1'b0;
          end
        end else if (LoadBefehlSignal) begin
          if (fehl_befehl) begin
            state_nx  = QUITT;
            bg_nx     = 1'b1;
            fehler_nx = 1'b1;
          end else begin
            state_nx         = LESEN;
            en_nx            = 1'b1;
            wr_nx            = 1'b0;
            adresse_nx       = BefehlAdresse[AW+1:2];
            zaehler_nx       = LAT4;
            quelle_befehl_nx = 1'b1;
          end
        end
      end

      LESEN: begin
        zaehler_nx = zaehler - 4'd1;
        if (!lese_anfrage) begin
          // Withdrawn: let the RAM cycle run out, discard the data.
          if (zaehler == 4'd1) begin
            en_nx    = 1'b0;
            state_nx = IDLE;
          end else begin
            state_nx = ABBRUCH;
          end
        end else if (zaehler == 4'd1) begin
          en_nx    = 1'b0;
          state_nx = QUITT;
          if (quelle_befehl) begin
            befehl_nx = MemLeseDaten;
            bg_nx     = 1'b1;
          end else begin
            lese_daten_nx = MemLeseDaten;
            dg_nx         = 1'b1;
          end
        end
      end

      ABBRUCH: begin
        zaehler_nx = zaehler - 4'd1;
        if (zaehler == 4'd1) begin
          en_nx    = 1'b0;
          state_nx = IDLE;
        end
      end

      SCHREIBEN: begin
        // The write strobe was already issued for this one cycle; a
        // withdrawn store only loses its ack.
        en_nx = 1'b0;
        wr_nx = 1'b0;
        if (StoreDatenSignal) begin
          ds_nx    = 1'b1;
          state_nx = QUITT;
        end else begin
          state_nx = IDLE;
        end
      end

      QUITT: begin
        if (!quitt_halten) begin
          bg_nx     = 1'b0;
          dg_nx     = 1'b0;
          ds_nx     = 1'b0;
          fehler_nx = 1'b0;
          state_nx  = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state              <= IDLE;
      zaehler            <= 4'd0;
      quelle_befehl      <= 1'b0;
      Befehl             <= 32'd0;
      LeseDaten          <= 32'd0;
      BefehlGeladen      <= 1'b0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;
      Ausrichtungsfehler <= 1'b0;
      MemEnable          <= 1'b0;
      MemSchreiben       <= 1'b0;
      MemAdresse         <= '0;
      MemSchreibDaten    <= 32'd0;
    end else begin
      state              <= state_nx;
      zaehler            <= zaehler_nx;
      quelle_befehl      <= quelle_befehl_nx;
      Befehl             <= befehl_nx;
      LeseDaten          <= lese_daten_nx;
      BefehlGeladen      <= bg_nx;
      DatenGeladen       <= dg_nx;
      DatenGespeichert   <= ds_nx;
      Ausrichtungsfehler <= fehler_nx;
      MemEnable          <= en_nx;
      MemSchreiben       <= wr_nx;
      MemAdresse         <= adresse_nx;
      MemSchreibDaten    <= schreib_daten_nx;
    end
  end

endmodule

// File: tb/tb_speicher_antwort.sv
// Bench for speicher_antwort: RAM model with LAT-cycle read latency, ack
// scoreboard (expected acks queued when a request is driven, popped when an
// ack rises) plus per-scenario cycle checks.
module tb_speicher_antwort;
  localparam int LAT = 2;
  localparam int AW  = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          LoadBefehlSignal, LoadDatenSignal, StoreDatenSignal;
  logic [31:0]   BefehlAdresse, DatenAdresse, SchreibDaten;
  logic [31:0]   Befehl, LeseDaten, MemSchreibDaten, MemLeseDaten;
  logic          BefehlGeladen, DatenGeladen, DatenGespeichert, Ausrichtungsfehler;
  logic          MemEnable, MemSchreiben;
  logic [AW-1:0] MemAdresse;

  speicher_antwort #(.LATENZ(LAT), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .LoadBefehlSignal(LoadBefehlSignal), .BefehlAdresse(BefehlAdresse),
    .LoadDatenSignal(LoadDatenSignal), .StoreDatenSignal(StoreDatenSignal),
    .DatenAdresse(DatenAdresse), .SchreibDaten(SchreibDaten),
    .Befehl(Befehl), .LeseDaten(LeseDaten),
    .BefehlGeladen(BefehlGeladen), .DatenGeladen(DatenGeladen),
    .DatenGespeichert(DatenGespeichert), .Ausrichtungsfehler(Ausrichtungsfehler),
    .MemEnable(MemEnable), .MemSchreiben(MemSchreiben), .MemAdresse(MemAdresse),
    .MemSchreibDaten(MemSchreibDaten), .MemLeseDaten(MemLeseDaten)
  );

  always #5 Clock = ~Clock;

  // RAM model: address seen at the edge after it is registered, data
  // available to be sampled LAT edges after the DUT's address edge.
  logic [31:0] ram [0:255];
  logic [31:0] rd_pipe [0:LAT-2];
  always @(posedge Clock) begin
    if (MemEnable && MemSchreiben) ram[MemAdresse] <= MemSchreibDaten;
    rd_pipe[0] <= ram[MemAdresse];
    for (int i = 1; i < LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign MemLeseDaten = rd_pipe[LAT-2];

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct { int art; logic [31:0] daten; logic fehl; } erw_t;  // art 0 fetch,1 load,2 store
  erw_t sb[$];

  logic bg_q = 0, dg_q = 0, ds_q = 0, hit;
  int mon_art;
  logic [31:0] mon_wert;
  erw_t e;

  always @(negedge Clock) begin
    hit = 0; mon_art = 0; mon_wert = 32'h0;
    if (BefehlGeladen && !bg_q)         begin hit = 1; mon_art = 0; mon_wert = Befehl; end
    else if (DatenGeladen && !dg_q)     begin hit = 1; mon_art = 1; mon_wert = LeseDaten; end
    else if (DatenGespeichert && !ds_q) begin hit = 1; mon_art = 2; mon_wert = 32'h0; end
    bg_q = BefehlGeladen; dg_q = DatenGeladen; ds_q = DatenGespeichert;
    if (hit) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_unexpected_ack: got ack kind %0d, none expected", mon_art);
      end else begin
        e = sb.pop_front();
        if (e.art !== mon_art || e.daten !== mon_wert || e.fehl !== Ausrichtungsfehler) begin
          tests_failed++;
          $display("FAIL scoreboard_ack: got kind %0d data %h flag %b, want kind %0d data %h flag %b",
                   mon_art, mon_wert, Ausrichtungsfehler, e.art, e.daten, e.fehl);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({BefehlGeladen, DatenGeladen, DatenGespeichert, Ausrichtungsfehler, MemEnable, MemSchreiben} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000000",
        {BefehlGeladen, DatenGeladen, DatenGespeichert, Ausrichtungsfehler, MemEnable, MemSchreiben});
    end
    tests_run++;
    if (Befehl !== 32'd0 || LeseDaten !== 32'd0 || MemAdresse !== '0 || MemSchreibDaten !== 32'd0) begin
      tests_failed++; $display("FAIL reset_regs: got %h %h %h %h want zeros", Befehl, LeseDaten, MemAdresse, MemSchreibDaten);
    end
    tick(); tick();
    Reset = 0;
  endtask

  task automatic test_fetch();
    int n, en;
    BefehlAdresse = 32'h10; LoadBefehlSignal = 1;
    sb.push_back('{0, 32'hDEADBEEF, 1'b0});
    tick();
    tests_run++;
    if (MemEnable !== 1'b1 || MemSchreiben !== 1'b0 || MemAdresse !== 8'd4) begin
      tests_failed++; $display("FAIL fetch_issue: got en %b wr %b adr %0d want 1 0 4", MemEnable, MemSchreiben, MemAdresse);
    end
    n = 0; en = 0;
    while (!BefehlGeladen && n < 20) begin if (MemEnable) en++; n++; tick(); end
    tests_run++;
    if (n != LAT) begin tests_failed++; $display("FAIL fetch_latency: got %0d want %0d", n, LAT); end
    tests_run++;
    if (en != LAT || MemEnable !== 1'b0) begin
      tests_failed++; $display("FAIL fetch_enable: got %0d cycles (now %b) want %0d (now 0)", en, MemEnable, LAT);
    end
    tests_run++;
    if (Befehl !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL fetch_data: got %h want deadbeef", Befehl); end
    LoadBefehlSignal = 0;
    tick();
    tests_run++;
    if (BefehlGeladen !== 1'b0) begin tests_failed++; $display("FAIL fetch_ack_drop: got %b want 0", BefehlGeladen); end
  endtask

  task automatic test_store_load();
    int n;
    StoreDatenSignal = 1; DatenAdresse = 32'h20; SchreibDaten = 32'h12345678;
    sb.push_back('{2, 32'h0, 1'b0});
    tick();
    tests_run++;
    if (MemSchreiben !== 1'b1 || MemEnable !== 1'b1 || MemAdresse !== 8'd8 || MemSchreibDaten !== 32'h12345678) begin
      tests_failed++; $display("FAIL store_issue: got wr %b en %b adr %0d data %h want 1 1 8 12345678",
        MemSchreiben, MemEnable, MemAdresse, MemSchreibDaten);
    end
    tick();
    tests_run++;
    if (MemSchreiben !== 1'b0 || MemEnable !== 1'b0 || DatenGespeichert !== 1'b1) begin
      tests_failed++; $display("FAIL store_ack: got wr %b en %b ack %b want 0 0 1", MemSchreiben, MemEnable, DatenGespeichert);
    end
    StoreDatenSignal = 0;
    tick();
    tests_run++;
    if (DatenGespeichert !== 1'b0) begin tests_failed++; $display("FAIL store_ack_drop: got %b want 0", DatenGespeichert); end
    LoadDatenSignal = 1;
    sb.push_back('{1, 32'h12345678, 1'b0});
    n = 0;
    while (!DatenGeladen && n < 20) begin n++; tick(); end
    tests_run++;
    if (n != LAT + 1 || LeseDaten !== 32'h12345678 || Befehl !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL load_after_store: got wait %0d data %h instr %h want %0d 12345678 deadbeef",
        n, LeseDaten, Befehl, LAT + 1);
    end
    LoadDatenSignal = 0;
    tick();
    tests_run++;
    if (DatenGeladen !== 1'b0) begin tests_failed++; $display("FAIL load_ack_drop: got %b want 0", DatenGeladen); end
  endtask

  task automatic test_priority();
    int n;
    BefehlAdresse = 32'h30; LoadBefehlSignal = 1;
    DatenAdresse  = 32'h28; LoadDatenSignal  = 1;
    sb.push_back('{1, 32'h0A0A0A0A, 1'b0});
    sb.push_back('{0, 32'hCAFEF00D, 1'b0});
    tick();
    tests_run++;
    if (MemAdresse !== 8'd10) begin tests_failed++; $display("FAIL prio_first_addr: got %0d want 10", MemAdresse); end
    n = 0;
    while (!DatenGeladen && n < 20) begin n++; tick(); end
    tests_run++;
    if (DatenGeladen !== 1'b1 || BefehlGeladen !== 1'b0) begin
      tests_failed++; $display("FAIL prio_load_first: got dack %b fack %b want 1 0", DatenGeladen, BefehlGeladen);
    end
    LoadDatenSignal = 0;
    tick();
    tests_run++;
    if (DatenGeladen !== 1'b0 || MemEnable !== 1'b0) begin
      tests_failed++; $display("FAIL prio_quitt_idle: got dack %b en %b want 0 0", DatenGeladen, MemEnable);
    end
    tick();
    tests_run++;
    if (MemEnable !== 1'b1 || MemAdresse !== 8'd12) begin
      tests_failed++; $display("FAIL prio_fetch_next: got en %b adr %0d want 1 12", MemEnable, MemAdresse);
    end
    n = 0;
    while (!BefehlGeladen && n < 20) begin n++; tick(); end
    tests_run++;
    if (Befehl !== 32'hCAFEF00D || LeseDaten !== 32'h0A0A0A0A) begin
      tests_failed++; $display("FAIL prio_fetch_data: got %h %h want cafef00d 0a0a0a0a", Befehl, LeseDaten);
    end
    LoadBefehlSignal = 0;
    tick();
  endtask

  task automatic test_abort();
    int n;
    DatenAdresse = 32'h24; LoadDatenSignal = 1;
    tick();
    LoadDatenSignal = 0;
    n = 0;
    while (MemEnable && n < 20) begin n++; tick(); end
    tests_run++;
    if (n != LAT) begin tests_failed++; $display("FAIL abort_duration: got %0d want %0d", n, LAT); end
    tests_run++;
    if (DatenGeladen !== 1'b0 || LeseDaten !== 32'h0A0A0A0A) begin
      tests_failed++; $display("FAIL abort_no_ack: got ack %b data %h want 0 0a0a0a0a", DatenGeladen, LeseDaten);
    end
    LoadDatenSignal = 1;
    sb.push_back('{1, 32'h55AA55AA, 1'b0});
    tick();
    tests_run++;
    if (MemEnable !== 1'b1 || MemAdresse !== 8'd9) begin
      tests_failed++; $display("FAIL abort_next_accept: got en %b adr %0d want 1 9", MemEnable, MemAdresse);
    end
    n = 0;
    while (!DatenGeladen && n < 20) begin n++; tick(); end
    tests_run++;
    if (LeseDaten !== 32'h55AA55AA) begin tests_failed++; $display("FAIL abort_next_data: got %h want 55aa55aa", LeseDaten); end
    LoadDatenSignal = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    StoreDatenSignal = 1; DatenAdresse = 32'h40; SchreibDaten = 32'h99999999;
    tick();
    tests_run++;
    if (MemSchreiben !== 1'b1) begin tests_failed++; $display("FAIL rstmid_write_issued: got %b want 1", MemSchreiben); end
    #1 Reset = 1;
    #1;
    tests_run++;
    if ({MemSchreiben, MemEnable, BefehlGeladen, DatenGeladen, DatenGespeichert} !== 5'b0) begin
      tests_failed++; $display("FAIL rstmid_outputs: got %b want 00000",
        {MemSchreiben, MemEnable, BefehlGeladen, DatenGeladen, DatenGespeichert});
    end
    StoreDatenSignal = 0;
    tick(); tick();
    Reset = 0;
    LoadDatenSignal = 1;
    sb.push_back('{1, 32'h11111111, 1'b0});
    tick();
    tests_run++;
    if (MemEnable !== 1'b1 || MemAdresse !== 8'd16) begin
      tests_failed++; $display("FAIL rstmid_idle_after: got en %b adr %0d want 1 16", MemEnable, MemAdresse);
    end
    n = 0;
    while (!DatenGeladen && n < 20) begin n++; tick(); end
    tests_run++;
    if (LeseDaten !== 32'h11111111) begin tests_failed++; $display("FAIL rstmid_no_write: got %h want 11111111", LeseDaten); end
    LoadDatenSignal = 0;
    tick();
  endtask

  task automatic test_misaligned();
`ifdef SPEICHER_AUSRICHTUNG_EN
    DatenAdresse = 32'h22; LoadDatenSignal = 1;
    sb.push_back('{1, 32'h11111111, 1'b1});
    tick();
    tests_run++;
    if (MemEnable !== 1'b0 || DatenGeladen !== 1'b1 || Ausrichtungsfehler !== 1'b1) begin
      tests_failed++; $display("FAIL misaligned_ack: got en %b ack %b flag %b want 0 1 1", MemEnable, DatenGeladen, Ausrichtungsfehler);
    end
    LoadDatenSignal = 0;
    tick();
    tests_run++;
    if (DatenGeladen !== 1'b0 || Ausrichtungsfehler !== 1'b0 || LeseDaten !== 32'h11111111) begin
      tests_failed++; $display("FAIL misaligned_clear: got ack %b flag %b data %h want 0 0 11111111",
        DatenGeladen, Ausrichtungsfehler, LeseDaten);
    end
`else
    int n;
    DatenAdresse = 32'h22; LoadDatenSignal = 1;
    sb.push_back('{1, 32'h12345678, 1'b0});
    tick();
    tests_run++;
    if (MemEnable !== 1'b1 || MemAdresse !== 8'd8) begin
      tests_failed++; $display("FAIL unaligned_ignored: got en %b adr %0d want 1 8", MemEnable, MemAdresse);
    end
    n = 0;
    while (!DatenGeladen && n < 20) begin n++; tick(); end
    tests_run++;
    if (Ausrichtungsfehler !== 1'b0 || LeseDaten !== 32'h12345678) begin
      tests_failed++; $display("FAIL unaligned_data: got flag %b data %h want 0 12345678", Ausrichtungsfehler, LeseDaten);
    end
    LoadDatenSignal = 0;
    tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[4]  = 32'hDEADBEEF;
    ram[9]  = 32'h55AA55AA;
    ram[10] = 32'h0A0A0A0A;
    ram[12] = 32'hCAFEF00D;
    ram[16] = 32'h11111111;
    Reset = 1;
    LoadBefehlSignal = 0; LoadDatenSignal = 0; StoreDatenSignal = 0;
    BefehlAdresse = 32'h0; DatenAdresse = 32'h0; SchreibDaten = 32'h0;

    test_reset();
    tick();
    test_fetch();
    test_store_load();
    test_priority();
    test_abort();
    test_reset_mid();
    test_misaligned();
    tick(); tick();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_leftover: got %0d pending acks want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
